// File: rtl/hvac_zone_ctrl_if.sv
// ---------------------------------------------------------------------------
// hvac_zone_ctrl_if
// Signal bundle between a zone controller and whatever drives its sensors.
//
// Optional feature macro: HVAC_MANUAL_OVR_EN (adds the manual force inputs A/B)
//
// Signals
//   en       zone enable                         (master -> slave)
//   temp     measured temperature, unsigned      (master -> slave)
//   setpt    target temperature, unsigned        (master -> slave)
//   A, B     force heat / force cool (optional)  (master -> slave)
//   LR       heater on                           (slave -> master)
//   LG       cooler on                           (slave -> master)
//   state_o  controller state, 00 IDLE 01 HEAT 10 COOL 11 HOLD
//
// There is no handshake: every input is a level that the controller samples
// on each rising clock edge, and every output is a registered level.
// ---------------------------------------------------------------------------
interface hvac_zone_ctrl_if #(
    parameter int TEMP_W = 8
);
    logic              en;
    logic [TEMP_W-1:0] temp;
    logic [TEMP_W-1:0] setpt;
    logic              LR;
    logic              LG;
    logic [1:0]        state_o;
`ifdef HVAC_MANUAL_OVR_EN
    logic              A;
    logic              B;

    modport master (output en, temp, setpt, A, B, input LR, LG, state_o);
    modport slave  (input en, temp, setpt, A, B, output LR, LG, state_o);
`else
    modport master (output en, temp, setpt, input LR, LG, state_o);
    modport slave  (input en, temp, setpt, output LR, LG, state_o);
`endif
endinterface

// File: rtl/hvac_zone_ctrl.sv
// ---------------------------------------------------------------------------
// hvac_zone_ctrl
// Single-zone heat/cool controller. Compares temp against setpt with a
// hysteresis band, keeps HEAT/COOL on for at least MIN_ON cycles unless the
// zone is disabled, and always passes through a LOCKOUT-cycle HOLD state
// between an episode and the next one.
//
// Optional feature macro: HVAC_MANUAL_OVR_EN
//   When defined, bus.A forces heat and bus.B forces cool (A wins), and a held
//   force suppresses the target-reached exit of its own mode.
//
// Ports
//   clock  rising-edge clock
//   rst    synchronous, active-high reset
//   bus    hvac_zone_ctrl_if.slave: en, temp, setpt, [A, B] in;
//          LR, LG, state_o out (all outputs registered)
// ---------------------------------------------------------------------------
module hvac_zone_ctrl #(
    parameter int TEMP_W  = 8,
    parameter int HYST    = 2,
    parameter int MIN_ON  = 4,
    parameter int LOCKOUT = 3
) (
    input  logic             clock,
    input  logic             rst,
    hvac_zone_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (MIN_ON > LOCKOUT) ? MIN_ON : LOCKOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TEMP_W:0]  HYST_X    = (TEMP_W + 1)'(HYST);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // dwell is 0 during the first cycle of a state, so "n cycles spent"
    // is reached when dwell == n-1 at the sampling edge.
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAT = 2'b01,
        S_COOL = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  dwell;
    logic [CNT_W-1:0]  dwell_next;
    logic              lr_q;
    logic              lg_q;

    logic [TEMP_W:0]   temp_x;
    logic [TEMP_W:0]   setpt_x;
    logic              heat_req;
    logic              cool_req;
    logic              force_heat;
    logic              force_cool;
    logic              run_met;
    logic              lock_met;

    // One extra bit so temp+HYST and setpt+HYST never wrap.
    assign temp_x   = {1'b0, bus.temp};
    assign setpt_x  = {1'b0, bus.setpt};
    assign heat_req = (temp_x + HYST_X) < setpt_x;
    assign cool_req = temp_x > (setpt_x + HYST_X);

`ifdef HVAC_MANUAL_OVR_EN
    assign force_heat = bus.A;
    assign force_cool = bus.B;
`else
    assign force_heat = 1'b0;
    assign force_cool = 1'b0;
`endif

    assign run_met  = (dwell >= RUN_LAST);
    assign lock_met = (dwell >= LOCK_LAST);

    always_comb begin
        state_next = state;
        dwell_next = dwell;

        case (state)
            S_IDLE: begin
                // Heat is tested first, which also makes A win over B.
                if (bus.en && (force_heat || heat_req)) begin
                    state_next = S_HEAT;
                end else if (bus.en && (force_cool || cool_req)) begin
                    state_next = S_COOL;
                end
            end
            S_HEAT: begin
                if (!bus.en) begin
                    state_next = S_HOLD;
                end else if (!force_heat && (bus.temp >= bus.setpt) && run_met) begin
                    state_next = S_HOLD;
                end
            end
            S_COOL: begin
                if (!bus.en) begin
                    state_next = S_HOLD;
                end else if (!force_cool && (bus.temp <= bus.setpt) && run_met) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                // en and the requests are deliberately not looked at here.
                if (lock_met) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (state_next != state) begin
            dwell_next = '0;
        end else if (dwell != CNT_SAT) begin
            dwell_next = dwell + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= S_IDLE;
            dwell <= '0;
            lr_q  <= 1'b0;
            lg_q  <= 1'b0;
        end else begin
            state <= state_next;
            dwell <= dwell_next;
            lr_q  <= (state_next == S_HEAT);
            lg_q  <= (state_next == S_COOL);
        end
    end

    assign bus.LR      = lr_q;
    assign bus.LG      = lg_q;
    assign bus.state_o = state;

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hvac_zone_ctrl
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model that tracks the zone mode and the number of cycles spent
// in it. A second instance with HYST=255 covers the wide-band boundary.
// Define HVAC_MANUAL_OVR_EN to exercise the manual force inputs.
// ---------------------------------------------------------------------------
module tb_hvac_zone_ctrl;

    localparam int TEMP_W  = 8;
    localparam int HYST    = 2;
    localparam int MIN_ON  = 4;
    localparam int LOCKOUT = 3;

    localparam int M_IDLE = 0;
    localparam int M_HEAT = 1;
    localparam int M_COOL = 2;
    localparam int M_HOLD = 3;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst   = 1'b1;
    logic              en    = 1'b0;
    logic [TEMP_W-1:0] temp  = '0;
    logic [TEMP_W-1:0] setpt = '0;
    logic              ovr_a = 1'b0;
    logic              ovr_b = 1'b0;

    hvac_zone_ctrl_if #(.TEMP_W(TEMP_W)) bus ();
    hvac_zone_ctrl_if #(.TEMP_W(TEMP_W)) bus_wide ();

    assign bus.en    = en;
    assign bus.temp  = temp;
    assign bus.setpt = setpt;
    assign bus_wide.en    = 1'b1;
    assign bus_wide.temp  = 8'd0;
    assign bus_wide.setpt = 8'd255;
`ifdef HVAC_MANUAL_OVR_EN
    assign bus.A      = ovr_a;
    assign bus.B      = ovr_b;
    assign bus_wide.A = 1'b0;
    assign bus_wide.B = 1'b0;
`endif

    hvac_zone_ctrl #(
        .TEMP_W(TEMP_W), .HYST(HYST), .MIN_ON(MIN_ON), .LOCKOUT(LOCKOUT)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    hvac_zone_ctrl #(
        .TEMP_W(TEMP_W), .HYST(255), .MIN_ON(MIN_ON), .LOCKOUT(LOCKOUT)
    ) dut_wide (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_wide)
    );

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    // m_cnt counts cycles spent in the current mode, including the cycle
    // that the edge being evaluated closes.
    int m_mode = M_IDLE;
    int m_cnt  = 0;
    int prev_state = M_IDLE;

    task automatic model_go(input int mode);
        m_mode = mode;
        m_cnt  = 1;
    endtask

    task automatic model_edge();
        int  t;
        int  s;
        bit  hr;
        bit  cr;
        t  = int'(temp);
        s  = int'(setpt);
        hr = (t + HYST) < s;
        cr = t > (s + HYST);
        if (rst) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (en && (ovr_a || hr))      model_go(M_HEAT);
                    else if (en && (ovr_b || cr)) model_go(M_COOL);
                    else m_cnt++;
                end
                M_HEAT: begin
                    if (!en) model_go(M_HOLD);
                    else if (!ovr_a && t >= s && m_cnt >= MIN_ON) model_go(M_HOLD);
                    else m_cnt++;
                end
                M_COOL: begin
                    if (!en) model_go(M_HOLD);
                    else if (!ovr_b && t <= s && m_cnt >= MIN_ON) model_go(M_HOLD);
                    else m_cnt++;
                end
                default: begin
                    if (m_cnt >= LOCKOUT) model_go(M_IDLE);
                    else m_cnt++;
                end
            endcase
        end
    endtask

    task automatic check_model();
        bit direct;
        chk("model_state", 32'(bus.state_o), 32'(m_mode));
        chk("model_LR", 32'(bus.LR), 32'(m_mode == M_HEAT));
        chk("model_LG", 32'(bus.LG), 32'(m_mode == M_COOL));
        direct = (prev_state == M_HEAT && int'(bus.state_o) == M_COOL) ||
                 (prev_state == M_COOL && int'(bus.state_o) == M_HEAT);
        chk("no_direct_swap", 32'(direct), 32'd0);
        prev_state = int'(bus.state_o);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge; the model consumes the
    // same values the DUT samples at the next edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;

        // Reset held two edges with a heat request pending.
        rst = 1'b1; en = 1'b1; temp = 8'd10; setpt = 8'd20;
        step();
        step();
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_LR", 32'(bus.LR), 32'd0);
        chk("rst_LG", 32'(bus.LG), 32'd0);
        rst = 1'b0;
        step();
        chk("first_heat_state", 32'(bus.state_o), 32'd1);
        chk("first_heat_LR", 32'(bus.LR), 32'd1);

        // Hysteresis edge and a normal heat episode.
        do_reset();
        setpt = 8'd20; temp = 8'd18;
        repeat (3) step();
        chk("hyst_idle", 32'(bus.state_o), 32'd0);
        temp = 8'd17;
        step();
        chk("hyst_heat", 32'(bus.state_o), 32'd1);
        repeat (5) step();
        temp = 8'd20;
        step();
        chk("target_hold", 32'(bus.state_o), 32'd3);
        chk("target_hold_LR", 32'(bus.LR), 32'd0);
        cnt = 1;
        while (bus.state_o == 2'b11 && cnt < 10) begin
            step();
            if (bus.state_o == 2'b11) cnt++;
        end
        chk("hold_len_a", 32'(cnt), 32'(LOCKOUT));
        chk("hold_to_idle", 32'(bus.state_o), 32'd0);

        // Overshoot: minimum run, lockout, then cooling.
        do_reset();
        setpt = 8'd20; temp = 8'd10;
        step();
        temp = 8'd25;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.LR !== 1'b1) break;
            cnt++;
        end
        chk("min_on_len", 32'(cnt), 32'(MIN_ON));
        chk("after_heat_hold", 32'(bus.state_o), 32'd3);
        cnt = 1;
        while (bus.state_o == 2'b11 && cnt < 10) begin
            step();
            if (bus.state_o == 2'b11) cnt++;
        end
        chk("hold_len_b", 32'(cnt), 32'(LOCKOUT));
        chk("idle_before_cool", 32'(bus.state_o), 32'd0);
        step();
        chk("cool_state", 32'(bus.state_o), 32'd2);
        chk("cool_LG", 32'(bus.LG), 32'd1);

        // Boundaries: no wrap-around at the top or bottom of the range.
        do_reset();
        setpt = 8'd254; temp = 8'd255;
        repeat (4) step();
        chk("bound_top_idle", 32'(bus.state_o), 32'd0);
        setpt = 8'd1; temp = 8'd0;
        repeat (4) step();
        chk("bound_bottom_idle", 32'(bus.state_o), 32'd0);
        chk("bound_wide_hyst_idle", 32'(bus_wide.state_o), 32'd0);
        chk("bound_wide_hyst_LR", 32'(bus_wide.LR), 32'd0);

        // Disable on the first HEAT cycle, then reset during HOLD.
        do_reset();
        setpt = 8'd20; temp = 8'd10;
        step();
        chk("en_drop_heat", 32'(bus.state_o), 32'd1);
        en = 1'b0;
        step();
        chk("en_drop_hold", 32'(bus.state_o), 32'd3);
        en = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_in_hold_state", 32'(bus.state_o), 32'd0);
        chk("rst_in_hold_LR", 32'(bus.LR), 32'd0);
        chk("rst_in_hold_LG", 32'(bus.LG), 32'd0);

`ifdef HVAC_MANUAL_OVR_EN
        // Manual override: A wins over B and holds HEAT past the target.
        do_reset();
        setpt = 8'd50; temp = 8'd50; ovr_a = 1'b1; ovr_b = 1'b1;
        step();
        chk("ovr_heat", 32'(bus.state_o), 32'd1);
        ovr_b = 1'b0;
        cnt = 0;
        repeat (10) begin
            step();
            if (bus.LR === 1'b1) cnt++;
        end
        chk("ovr_hold_LR", 32'(cnt), 32'd10);
        ovr_a = 1'b0;
        step();
        chk("ovr_release_hold", 32'(bus.state_o), 32'd3);
`endif

        // Randomized run around the setpoint.
        do_reset();
        setpt = 8'd40; temp = 8'd40;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) setpt = 8'($urandom_range(10, 240));
            if ($urandom_range(0, 2) == 0)
                temp = 8'(int'(setpt) + int'($urandom_range(0, 14)) - 7);
            en  = ($urandom_range(0, 11) != 0);
            rst = ($urandom_range(0, 79) == 0);
`ifdef HVAC_MANUAL_OVR_EN
            ovr_a = ($urandom_range(0, 19) == 0);
            ovr_b = ($urandom_range(0, 19) == 0);
`endif
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
